// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared state encoding and default geometry for ram_n
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_READY = 1'b1
    } ram_state_e;

    localparam int RAM_WIDTH_DEF = 16;
    localparam int RAM_DEPTH_DEF = 8;

endpackage

// File: rtl/ram_clear_fsm.sv
// rtl/ram_clear_fsm.sv - post-reset zero-fill sequencer: state, clear pointer, busy
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    ram_state_e        state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RAM_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_we     = 1'b0;
        // rst is folded in so requests are locked out on the reset edge itself
        busy       = rst || (state == RAM_CLEAR);
        case (state)
            RAM_CLEAR: begin
                clr_we   = !rst;
                ptr_next = ptr + 1'b1;
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_next = RAM_READY;
                    ptr_next   = '0;
                end
            end
            RAM_READY: begin
                state_next = RAM_READY;
            end
            default: begin
                state_next = RAM_CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    assign clr_addr = ptr;

endmodule

// File: rtl/ram_n.sv
// rtl/ram_n.sv - single-port RAM with registered read strobe; RAM_BYPASS_EN selects write-through on collision
module ram_n
    import ram_pkg::*;
#(
    parameter int WIDTH = RAM_WIDTH_DEF,
    parameter int DEPTH = RAM_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] sel,
    input  logic              load,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              sel_ok;
    logic [WIDTH-1:0]  rd_word;

    ram_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Only non-power-of-two depths can address past the array
    assign sel_ok = (32'(sel) < DEPTH);

    always_comb begin
        rd_word = '0;
        if (sel_ok) begin
`ifdef RAM_BYPASS_EN
            rd_word = load ? in : mem[sel];
`else
            rd_word = mem[sel];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (!busy && load && sel_ok) begin
            mem[sel] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (!busy && rd_en) begin
                out       <= rd_word;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_n.sv
// tb/tb_ram_n.sv - scoreboard bench for ram_n, default 8x16 plus a 5x8 instance
module tb_ram_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] in;
    logic [2:0]  sel;
    logic        load, rd_en;
    logic [15:0] out;
    logic        out_valid, busy;

    logic        rst2;
    logic [7:0]  in2;
    logic [2:0]  sel2;
    logic        load2, rd2;
    logic [7:0]  out2;
    logic        ov2, busy2;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  exp2_q[$];

    ram_n dut (
        .clk(clk), .rst(rst), .in(in), .sel(sel), .load(load), .rd_en(rd_en),
        .out(out), .out_valid(out_valid), .busy(busy)
    );

    ram_n #(.WIDTH(8), .DEPTH(5)) dut2 (
        .clk(clk), .rst(rst2), .in(in2), .sel(sel2), .load(load2), .rd_en(rd2),
        .out(out2), .out_valid(ov2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected actual=%0h required=none", out);
            end else begin
                chk("rd", 32'(out), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (ov2 === 1'b1) begin
            if (exp2_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd2_unexpected actual=%0h required=none", out2);
            end else begin
                chk("rd2", 32'(out2), 32'(exp2_q.pop_front()));
            end
        end
    end

    task automatic cyc(input logic ld, input logic rd, input logic [2:0] a,
                       input logic [15:0] d, input logic [15:0] e);
        load = ld; rd_en = rd; sel = a; in = d;
        if (rd) exp_q.push_back(e);
        @(negedge clk);
        load = 1'b0; rd_en = 1'b0;
    endtask

    task automatic cyc2(input logic ld, input logic rd, input logic [2:0] a,
                        input logic [7:0] d, input logic [7:0] e);
        load2 = ld; rd2 = rd; sel2 = a; in2 = d;
        if (rd) exp2_q.push_back(e);
        @(negedge clk);
        load2 = 1'b0; rd2 = 1'b0;
    endtask

    task automatic clear_len(output int n);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clear_len2(output int n);
        n = 0;
        while (busy2 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [15:0] pat [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                             16'h5555, 16'h6666, 16'h7777, 16'h8888};

    initial begin
        int n;
        rst = 1'b1; in = '0; sel = '0; load = 1'b0; rd_en = 1'b0;
        rst2 = 1'b1; in2 = '0; sel2 = '0; load2 = 1'b0; rd2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_valid", 32'(out_valid), 32'h0);
        chk("reset_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        clear_len(n);
        chk("clear_len_init", n, 8);

        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 3'(i), pat[i], 16'h0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3'(i), 16'h0, pat[i]);

        // Reset pulse, then hammer load/rd_en at addr 2 for the whole clear
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load = 1'b1; rd_en = 1'b1; sel = 3'd2; in = 16'hFFFF;
        clear_len(n);
        load = 1'b0; rd_en = 1'b0;
        chk("clear_len_pulse", n, 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 3'(i), 16'h0, 16'h0000);

        cyc(1'b1, 1'b0, 3'd3, 16'h4444, 16'h0);
`ifdef RAM_BYPASS_EN
        cyc(1'b1, 1'b1, 3'd3, 16'hABCD, 16'hABCD);
`else
        cyc(1'b1, 1'b1, 3'd3, 16'hABCD, 16'h4444);
`endif
        cyc(1'b0, 1'b1, 3'd3, 16'h0, 16'hABCD);
        cyc(1'b1, 1'b0, 3'd7, 16'h5A5A, 16'h0);
        cyc(1'b0, 1'b1, 3'd7, 16'h0, 16'h5A5A);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midclear_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("midclear_rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        clear_len(n);
        chk("clear_len_mid", n, 8);
        cyc(1'b0, 1'b1, 3'd3, 16'h0, 16'h0000);
        cyc(1'b0, 1'b1, 3'd7, 16'h0, 16'h0000);

        rst2 = 1'b0;
        clear_len2(n);
        chk("clear_len_d5", n, 5);
        cyc2(1'b1, 1'b0, 3'd4, 8'h5A, 8'h0);
        cyc2(1'b1, 1'b0, 3'd6, 8'h77, 8'h0);
        cyc2(1'b0, 1'b1, 3'd6, 8'h0, 8'h00);
        cyc2(1'b0, 1'b1, 3'd4, 8'h0, 8'h5A);
        cyc2(1'b0, 1'b1, 3'd0, 8'h0, 8'h00);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        chk("queue2_drained", 32'(exp2_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_n.md
# ram_n

Parametrised single-port synchronous RAM for the CPU memory hierarchy; the generalised successor to the fixed 8×16 RAM8 block. It stores DEPTH words of WIDTH bits with clocked writes and a registered read that carries a valid strobe. After reset it clears every location to zero, signalling `busy` while it does so. It sits behind the CPU data path as working memory and as the building block for larger RAM banks.

## Interface
- `WIDTH`, 16, data word width in bits (≥1)
- `DEPTH`, 8, number of words (≥2; need not be a power of two)
- `ADDR_W`, $clog2(DEPTH), address width; derived, not overridden
- `clk` input 1: the single clock; all state updates on the rising edge
- `rst` input 1: reset, synchronous and active-high
- `in` input WIDTH: write data
- `sel` input ADDR_W: word address for both read and write
- `load` input 1: write enable
- `rd_en` input 1: read request
- `out` output WIDTH: registered read data
- `out_valid` output 1: one-cycle strobe; `out` carries fresh data
- `busy` output 1: clear sequence active; requests ignored

## Operation
- Two-state FSM: CLEAR and READY.
- `rst`=1 at an edge: state←CLEAR, clear pointer←0, `out`←0, `out_valid`←0, `busy`=1. Memory contents are not touched during that edge.
- CLEAR (with `rst`=0): each edge writes 0 to mem[pointer] and increments the pointer. At pointer==DEPTH-1, write it and go to READY.
- In CLEAR, `load` and `rd_en` are ignored: no write, no `out_valid`.
- In READY, `load`=1 writes `in` to mem[`sel`] at the edge.
- In READY, `rd_en`=1 captures mem[`sel`] into `out` and sets `out_valid`=1 for exactly one cycle. With `rd_en`=0, `out` holds its last value and `out_valid`=0.
- If `load` and `rd_en` are both 1 at the same address, the write always happens. Read data depends on the Configuration section.
- `sel` ≥ DEPTH (only possible for non-power-of-two DEPTH): the write is dropped, and a read returns 0 with `out_valid`=1.
- If `rst` is asserted mid-clear, the clear restarts from address 0. If it is asserted in READY, the full clear re-runs.

## Timing
- Reset values: `out`=0, `out_valid`=0, `busy`=1.
- `busy` is combinational from state and reads 1 while `rst`=1.
- After `rst` falls, the clear takes DEPTH edges. `busy` falls after the DEPTH-th edge, and the first accepted request is at edge DEPTH+1.
- Write latency: data is visible to a read issued on the next edge.
- Read latency: 1 cycle. Request at edge N gives `out` and `out_valid` valid after edge N.
- Throughput: one read and/or one write per cycle.

## Configuration
- `RAM_BYPASS_EN` defined: on a same-address `load`+`rd_en`, `out` returns the new `in` (write-through forwarding).
- `RAM_BYPASS_EN` undefined: the same case returns the old stored word (read-before-write).
- All other behaviour is identical in both builds.

## Structure
- Package `ram_pkg` holds:
  - the state enum (`RAM_CLEAR`, `RAM_READY`)
  - default constants `RAM_WIDTH_DEF`=16 and `RAM_DEPTH_DEF`=8
- Sub-module `ram_clear_fsm` holds the state register, the clear pointer and `busy`. It outputs the clear write enable and clear address to the `ram_n` storage array.

## Test plan
- **Reset clear:** preload via backdoor, pulse `rst` 1 cycle, DEPTH=8 → `busy`=1 for 8 edges; every read afterwards returns 0000.
- **Write/read all:** write 1111…8888 to addresses 0–7, then read 0–7 → `out`=1111…8888, each with a one-cycle `out_valid`, 1-cycle latency.
- **Collision:** addr 3 holds 4444; `load`=1, `rd_en`=1, `in`=ABCD, `sel`=3 → `out`=4444 without the macro, ABCD with `RAM_BYPASS_EN`; a later read returns ABCD in both builds.
- **Busy lockout:** `load`=1, `in`=FFFF at addr 2 during CLEAR → ignored, no `out_valid`; a read after clear returns 0000.
- **Mid-clear reset:** `rst` reasserted at clear edge 4 → pointer restarts and `busy` lasts 8 more edges.
- **Non-power-of-two:** DEPTH=5, WIDTH=8, write 77 to `sel`=6 → dropped; read `sel`=6 → `out`=00, `out_valid`=1.
